riscv_data_mem: RTL and testbench

//  Parametrised data memory and load/store unit for the multi-cycle riscv core, succeeding the fixed word-only memory.

---
 rtl/riscv_data_mem_pkg.sv | 42 ++++
 rtl/riscv_data_mem_lsu_align.sv | 72 +++++++
 rtl/riscv_data_mem.sv | 181 ++++++++++++++++++
 tb/tb_riscv_data_mem.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_data_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_data_mem_pkg
// Shared load/store definitions for the multi-cycle riscv core: RV32I
// load/store funct3 encodings, access-size decoding, the latched request
// record and a byte-lane helper used by the data memory and its aligner.
// -----------------------------------------------------------------------------
package riscv_data_mem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size as carried in funct3[1:0]
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_NONE = 2'b11
  } size_e;

  // Request record captured at the accepting edge
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Maps a word lane (lane 0 = bits 7:0) to the byte offset it occupies in
  // storage. Big-endian puts offset 0 in the most significant lane.
  function automatic logic [1:0] lane_to_byte(input logic [1:0] lane,
                                              input logic       big_endian);
    return big_endian ? ~lane : lane;
  endfunction

endpackage

// File: rtl/riscv_data_mem_lsu_align.sv
// -----------------------------------------------------------------------------
// riscv_lsu_align
// Combinational byte-lane steering for loads and stores.
//  funct3_i      access type (B/H/W/BU/HU)
//  addr_i        low two address bits
//  wdata_i       LSB-justified store data
//  rword_i       storage word read at the aligned address (lane 0 = bits 7:0)
//  big_endian_i  byte order of storage
//  be_o          byte-lane write mask
//  wdata_o       store data shifted onto its lanes
//  rdata_o       extended load result
//  misaligned_o  H on odd address or W on non-multiple-of-4 address
// -----------------------------------------------------------------------------
module riscv_lsu_align
  import riscv_data_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  input  logic        big_endian_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  size_e       size;
  logic [1:0]  lane_off;
  logic [4:0]  shamt;
  logic [31:0] lane_data;

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    size         = size_e'(funct3_i[1:0]);
    misaligned_o = 1'b0;
    lane_off     = 2'd0;
    be_o         = 4'b0000;
    unique case (size)
      SZ_BYTE: begin
        lane_off = big_endian_i ? ~addr_i : addr_i;
        be_o     = 4'b0001 << lane_off;
      end
      SZ_HALF: begin
        // big-endian halfword at offset k occupies lanes 3-k and 2-k
        lane_off     = big_endian_i ? 2'(2'd2 - addr_i) : addr_i;
        be_o         = 4'b0011 << lane_off;
        misaligned_o = addr_i[0];
      end
      SZ_WORD: begin
        be_o         = 4'b1111;
        misaligned_o = (addr_i != 2'd0);
      end
      default: ;
    endcase

    shamt     = {lane_off, 3'b000};
    wdata_o   = wdata_i << shamt;
    lane_data = rword_i >> shamt;

    unique case (funct3_i)
      F3_LB:   rdata_o = {{24{lane_data[7]}}, lane_data[7:0]};
      F3_LH:   rdata_o = {{16{lane_data[15]}}, lane_data[15:0]};
      F3_LW:   rdata_o = lane_data;
      F3_LBU:  rdata_o = {24'd0, lane_data[7:0]};
      F3_LHU:  rdata_o = {16'd0, lane_data[15:0]};
      default: rdata_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/riscv_data_mem.sv
// -----------------------------------------------------------------------------
// riscv_data_mem
// Byte-addressed data memory and load/store unit for the multi-cycle core.
// Accepts one request in IDLE, spends WAIT_STATES cycles in WAIT, then pulses
// rsp_valid_o for one RESP cycle. Includes a memory-mapped GPIO register.
//  clk_i        clock
//  rst_i        synchronous active-high reset
//  req_valid_i  request present          req_ready_o  high only in IDLE
//  req_we_i     1 = store                req_funct3_i RV32I load/store funct3
//  req_addr_i   byte address             req_wdata_i  LSB-justified store data
//  rsp_valid_o  one-cycle completion     rsp_rdata_o  extended load data
//  rsp_err_o    misaligned / illegal funct3 / out of range
//  gpio_o       GPIO register contents
// -----------------------------------------------------------------------------
module riscv_data_mem
  import riscv_data_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 1,
  parameter bit          BIG_ENDIAN  = 1'b0,
  parameter int          GPIO_WIDTH  = 8,
  parameter logic [31:0] GPIO_ADDR   = 32'h0000_1000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [GPIO_WIDTH-1:0] gpio_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (WAIT_STATES > 2) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  mem_req_t              req_q, req_d, req_cur;
  logic [GPIO_WIDTH-1:0] gpio_q, gpio_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [7:0]            mem_q [0:DEPTH-1];
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [31:0]           rword, wdata_sh, load_data;
  logic [3:0]            be;
  logic                  misaligned, bad_f3, in_mem, is_gpio, err;
  logic                  handshake, enter_resp, mem_we;

  assign req_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign handshake   = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign gpio_o      = gpio_q;

  // In IDLE the live request is the one being accepted; with zero wait states
  // it completes on the accepting edge, so it must be decoded directly.
  always_comb begin
    req_cur = req_q;
    if (state_q == ST_IDLE) begin
      req_cur.we     = req_we_i;
      req_cur.funct3 = req_funct3_i;
      req_cur.addr   = req_addr_i;
      req_cur.wdata  = req_wdata_i;
    end
  end

  assign word_idx = req_cur.addr[ADDR_WIDTH-1:2];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rword[8*i +: 8] = mem_q[{word_idx, lane_to_byte(2'(i), BIG_ENDIAN)}];
    end
  end

  riscv_lsu_align u_align (
    .funct3_i     (req_cur.funct3),
    .addr_i       (req_cur.addr[1:0]),
    .wdata_i      (req_cur.wdata),
    .rword_i      (rword),
    .big_endian_i (BIG_ENDIAN),
    .be_o         (be),
    .wdata_o      (wdata_sh),
    .rdata_o      (load_data),
    .misaligned_o (misaligned)
  );

  // Legality of the request being completed
  always_comb begin
    bad_f3  = req_cur.we ? !(req_cur.funct3 inside {F3_SB, F3_SH, F3_SW})
                         : !(req_cur.funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    in_mem  = (req_cur.addr >> ADDR_WIDTH) == 32'd0;
    is_gpio = (req_cur.addr == GPIO_ADDR);
    // GPIO is word-only; F3_LW and F3_SW share the encoding
    err     = bad_f3 || misaligned || !(in_mem || is_gpio) ||
              (is_gpio && (req_cur.funct3 != F3_LW));
  end

  assign enter_resp = ((state_q == ST_IDLE) && handshake && (WAIT_STATES == 0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == '0));
  assign mem_we     = enter_resp && !rst_i && !err && req_cur.we && !is_gpio;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    gpio_d      = gpio_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          req_d = req_cur;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      rsp_err_d = err;
      if (err || req_cur.we) rsp_rdata_d = 32'd0;
      else if (is_gpio)      rsp_rdata_d = 32'(gpio_q);
      else                   rsp_rdata_d = load_data;
      if (!err && req_cur.we && is_gpio) gpio_d = req_cur.wdata[GPIO_WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      gpio_q      <= '0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      gpio_q      <= gpio_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM; only the
  // write is gated by rst_i so an interrupted store never commits.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[{word_idx, lane_to_byte(2'(i), BIG_ENDIAN)}] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_data_mem.sv
module tb_riscv_data_mem;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  localparam logic [31:0] GPIO = 32'h0000_1000;
  localparam int D = 0, BE = 1, W0 = 2, W3 = 3;  // instance indices

  logic        clk = 1'b0;
  logic        rst       [4];
  logic        req_valid [4];
  logic        req_ready [4];
  logic        req_we    [4];
  logic [2:0]  req_f3    [4];
  logic [31:0] req_addr  [4];
  logic [31:0] req_wdata [4];
  logic        rsp_valid [4];
  logic [31:0] rsp_rdata [4];
  logic        rsp_err   [4];
  logic [7:0]  gpio      [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_data_mem u_def (
    .clk_i(clk), .rst_i(rst[D]), .req_valid_i(req_valid[D]), .req_ready_o(req_ready[D]),
    .req_we_i(req_we[D]), .req_funct3_i(req_f3[D]), .req_addr_i(req_addr[D]),
    .req_wdata_i(req_wdata[D]), .rsp_valid_o(rsp_valid[D]), .rsp_rdata_o(rsp_rdata[D]),
    .rsp_err_o(rsp_err[D]), .gpio_o(gpio[D]));

  riscv_data_mem #(.BIG_ENDIAN(1'b1)) u_be (
    .clk_i(clk), .rst_i(rst[BE]), .req_valid_i(req_valid[BE]), .req_ready_o(req_ready[BE]),
    .req_we_i(req_we[BE]), .req_funct3_i(req_f3[BE]), .req_addr_i(req_addr[BE]),
    .req_wdata_i(req_wdata[BE]), .rsp_valid_o(rsp_valid[BE]), .rsp_rdata_o(rsp_rdata[BE]),
    .rsp_err_o(rsp_err[BE]), .gpio_o(gpio[BE]));

  riscv_data_mem #(.WAIT_STATES(0)) u_w0 (
    .clk_i(clk), .rst_i(rst[W0]), .req_valid_i(req_valid[W0]), .req_ready_o(req_ready[W0]),
    .req_we_i(req_we[W0]), .req_funct3_i(req_f3[W0]), .req_addr_i(req_addr[W0]),
    .req_wdata_i(req_wdata[W0]), .rsp_valid_o(rsp_valid[W0]), .rsp_rdata_o(rsp_rdata[W0]),
    .rsp_err_o(rsp_err[W0]), .gpio_o(gpio[W0]));

  riscv_data_mem #(.WAIT_STATES(3)) u_w3 (
    .clk_i(clk), .rst_i(rst[W3]), .req_valid_i(req_valid[W3]), .req_ready_o(req_ready[W3]),
    .req_we_i(req_we[W3]), .req_funct3_i(req_f3[W3]), .req_addr_i(req_addr[W3]),
    .req_wdata_i(req_wdata[W3]), .rsp_valid_o(rsp_valid[W3]), .rsp_rdata_o(rsp_rdata[W3]),
    .rsp_err_o(rsp_err[W3]), .gpio_o(gpio[W3]));

  // One access on instance u. Starts and ends at a negedge. lat counts edges
  // from the accepting edge (=1) to the edge after which rsp_valid is seen.
  // After acceptance the request inputs are scrambled; they must be ignored.
  task automatic do_access(input int u, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output bit ready_low, output bit pulse_ok);
    bit got = 0;
    for (int k = 0; k < 20 && !req_ready[u]; k++) @(negedge clk);
    req_we[u] = we; req_f3[u] = f3; req_addr[u] = addr; req_wdata[u] = wdata;
    req_valid[u] = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    req_valid[u] = 1'b0;
    req_we[u] = ~we; req_f3[u] = 3'b111; req_addr[u] = ~addr; req_wdata[u] = ~wdata;
    ready_low = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid[u]) begin got = 1; break; end
      if (req_ready[u]) ready_low = 0;
      @(posedge clk);
      lat++;
    end
    rdata = rsp_rdata[u];
    err   = rsp_err[u];
    if (req_ready[u]) ready_low = 0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rsp_timeout inst=%0d got=no_rsp_valid exp=rsp_valid within 20 edges", u);
    end
    @(negedge clk);
    pulse_ok = !rsp_valid[u];
  endtask

  task automatic test_reset();
    for (int u = 0; u < 4; u++) begin
      rst[u] = 1'b1; req_valid[u] = 1'b1; req_we[u] = 1'b1; req_f3[u] = SW;
      req_addr[u] = 32'd0; req_wdata[u] = 32'hFFFF_FFFF;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      checks++; if (req_ready[u] !== 1'b0) begin failures++; $display("FAIL rst_ready inst=%0d got=%b exp=0", u, req_ready[u]); end
      checks++; if (rsp_valid[u] !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid inst=%0d got=%b exp=0", u, rsp_valid[u]); end
      checks++; if (rsp_err[u] !== 1'b0) begin failures++; $display("FAIL rst_rsp_err inst=%0d got=%b exp=0", u, rsp_err[u]); end
      checks++; if (rsp_rdata[u] !== 32'd0) begin failures++; $display("FAIL rst_rdata inst=%0d got=%h exp=0", u, rsp_rdata[u]); end
      checks++; if (gpio[u] !== 8'h00) begin failures++; $display("FAIL rst_gpio inst=%0d got=%h exp=00", u, gpio[u]); end
      rst[u] = 1'b0; req_valid[u] = 1'b0;
    end
    #1;
    for (int u = 0; u < 4; u++) begin
      checks++; if (req_ready[u] !== 1'b1) begin failures++; $display("FAIL rst_release_ready inst=%0d got=%b exp=1", u, req_ready[u]); end
    end
    @(negedge clk);
  endtask

  task automatic test_defaults();
    logic [31:0] rd; logic er; int lat; bit rl, po;
    do_access(D, 1, SW, 32'd0, 32'h0001_F000, rd, er, lat, rl, po);
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL sw0_rsp got=err%b/%h exp=err0/00000000", er, rd); end
    checks++; if (lat != 2) begin failures++; $display("FAIL sw0_latency got=%0d exp=2", lat); end
    do_access(D, 0, LW, 32'd0, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h0001_F000 || er !== 1'b0) begin failures++; $display("FAIL lw0 got=err%b/%h exp=err0/0001f000", er, rd); end
    checks++; if (lat != 2) begin failures++; $display("FAIL lw0_latency got=%0d exp=2", lat); end
    checks++; if (!rl) begin failures++; $display("FAIL lw0_ready_low got=ready_high exp=ready_low_during_access"); end
    checks++; if (!po) begin failures++; $display("FAIL lw0_pulse got=rsp_valid_2_cycles exp=1_cycle"); end
    do_access(D, 0, LBU, 32'd0, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h0000_0000) begin failures++; $display("FAIL mem0_le got=%h exp=00000000", rd); end
    do_access(D, 0, LBU, 32'd2, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h0000_0001) begin failures++; $display("FAIL mem2_le got=%h exp=00000001", rd); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic er; int lat; bit rl, po;
    do_access(D, 1, SW, 32'd4, 32'h1122_3344, rd, er, lat, rl, po);
    do_access(D, 1, SB, 32'd5, 32'h0000_0080, rd, er, lat, rl, po);
    do_access(D, 0, LB, 32'd5, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb5 got=%h exp=ffffff80", rd); end
    do_access(D, 0, LBU, 32'd5, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL lbu5 got=%h exp=00000080", rd); end
    do_access(D, 0, LW, 32'd4, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h1122_8044) begin failures++; $display("FAIL sb_lanes got=%h exp=11228044", rd); end
    do_access(D, 1, SH, 32'd10, 32'hFFFF_8001, rd, er, lat, rl, po);
    do_access(D, 0, LH, 32'd10, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'hFFFF_8001) begin failures++; $display("FAIL lh10 got=%h exp=ffff8001", rd); end
    do_access(D, 0, LHU, 32'd10, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h0000_8001) begin failures++; $display("FAIL lhu10 got=%h exp=00008001", rd); end
    do_access(D, 0, LBU, 32'd11, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL lbu11 got=%h exp=00000080", rd); end
  endtask

  task automatic test_big_endian();
    logic [31:0] rd; logic er; int lat; bit rl, po;
    do_access(BE, 1, SH, 32'd6, 32'h0000_BEEF, rd, er, lat, rl, po);
    do_access(BE, 0, LBU, 32'd6, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h0000_00BE) begin failures++; $display("FAIL be_mem6 got=%h exp=000000be", rd); end
    do_access(BE, 0, LBU, 32'd7, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h0000_00EF) begin failures++; $display("FAIL be_mem7 got=%h exp=000000ef", rd); end
    do_access(BE, 1, SW, 32'd8, 32'h1122_3344, rd, er, lat, rl, po);
    do_access(BE, 0, LBU, 32'd8, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h0000_0011) begin failures++; $display("FAIL be_mem8 got=%h exp=00000011", rd); end
    do_access(BE, 0, LH, 32'd10, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h0000_3344) begin failures++; $display("FAIL be_lh10 got=%h exp=00003344", rd); end
    do_access(BE, 0, LW, 32'd8, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h1122_3344) begin failures++; $display("FAIL be_lw8 got=%h exp=11223344", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit rl, po;
    do_access(D, 1, SW, 32'd0, 32'hCAFE_F00D, rd, er, lat, rl, po);
    do_access(D, 0, LW, 32'd2, 32'd0, rd, er, lat, rl, po);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL lw2_misaligned got=err%b/%h exp=err1/00000000", er, rd); end
    do_access(D, 1, SH, 32'd3, 32'h0000_5555, rd, er, lat, rl, po);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL sh3_misaligned got=err%b exp=err1", er); end
    do_access(D, 0, LH, 32'd1, 32'd0, rd, er, lat, rl, po);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL lh1_misaligned got=err%b/%h exp=err1/00000000", er, rd); end
    do_access(D, 0, 3'b011, 32'd0, 32'd0, rd, er, lat, rl, po);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL f3_011 got=err%b/%h exp=err1/00000000", er, rd); end
    do_access(D, 1, 3'b100, 32'd0, 32'h0000_0000, rd, er, lat, rl, po);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL store_f3_100 got=err%b exp=err1", er); end
    do_access(D, 1, SW, 32'd1024, 32'h0000_0000, rd, er, lat, rl, po);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL sw_depth got=err%b exp=err1", er); end
    do_access(D, 0, LW, 32'd0, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin failures++; $display("FAIL err_no_write got=err%b/%h exp=err0/cafef00d", er, rd); end
    do_access(D, 0, LW, 32'd1024, 32'd0, rd, er, lat, rl, po);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL lw_depth got=err%b/%h exp=err1/00000000", er, rd); end
  endtask

  task automatic test_gpio();
    logic [31:0] rd; logic er; int lat; bit rl, po;
    do_access(D, 1, SW, GPIO, 32'h0000_00A5, rd, er, lat, rl, po);
    checks++; if (er !== 1'b0 || gpio[D] !== 8'hA5) begin failures++; $display("FAIL gpio_sw got=err%b/gpio%h exp=err0/gpioa5", er, gpio[D]); end
    do_access(D, 0, LW, GPIO, 32'd0, rd, er, lat, rl, po);
    checks++; if (er !== 1'b0 || rd !== 32'h0000_00A5) begin failures++; $display("FAIL gpio_lw got=err%b/%h exp=err0/000000a5", er, rd); end
    do_access(D, 1, SB, GPIO, 32'h0000_0011, rd, er, lat, rl, po);
    checks++; if (er !== 1'b1 || gpio[D] !== 8'hA5) begin failures++; $display("FAIL gpio_sb got=err%b/gpio%h exp=err1/gpioa5", er, gpio[D]); end
    do_access(D, 0, LBU, GPIO, 32'd0, rd, er, lat, rl, po);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL gpio_lbu got=err%b/%h exp=err1/00000000", er, rd); end
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic er; int lat; bit rl, po;
    do_access(W0, 1, SW, 32'd16, 32'hDEAD_BEEF, rd, er, lat, rl, po);
    checks++; if (lat != 1) begin failures++; $display("FAIL ws0_latency got=%0d exp=1", lat); end
    do_access(W0, 0, LW, 32'd16, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'hDEAD_BEEF || !po) begin failures++; $display("FAIL ws0_lw got=%h pulse_ok=%0d exp=deadbeef pulse_ok=1", rd, po); end
    do_access(W3, 1, SW, 32'd20, 32'h0BAD_CAFE, rd, er, lat, rl, po);
    checks++; if (lat != 4) begin failures++; $display("FAIL ws3_latency got=%0d exp=4", lat); end
    do_access(W3, 0, LW, 32'd20, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h0BAD_CAFE || !rl) begin failures++; $display("FAIL ws3_lw got=%h ready_low=%0d exp=0badcafe ready_low=1", rd, rl); end
  endtask

  task automatic test_back_to_back();
    int exp_gap [2] = '{2, 5};
    int units [2] = '{W0, W3};
    for (int n = 0; n < 2; n++) begin
      int u = units[n];
      int first = -1, second = -1;
      bit acc;
      req_we[u] = 1'b0; req_f3[u] = LW; req_addr[u] = 32'd16; req_wdata[u] = 32'd0;
      req_valid[u] = 1'b1;
      for (int e = 1; e <= 14; e++) begin
        acc = req_ready[u];
        @(posedge clk);
        if (acc && first < 0) first = e;
        else if (acc && second < 0) second = e;
        @(negedge clk);
      end
      req_valid[u] = 1'b0;
      checks++;
      if (first < 0 || second < 0 || second - first != exp_gap[n]) begin
        failures++;
        $display("FAIL b2b_gap inst=%0d got=%0d exp=%0d", u, second - first, exp_gap[n]);
      end
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; bit rl, po;
    bit saw_rsp = 0;
    do_access(D, 1, SW, 32'd8, 32'h0BAD_F00D, rd, er, lat, rl, po);
    req_we[D] = 1'b1; req_f3[D] = SW; req_addr[D] = 32'd8; req_wdata[D] = 32'h0000_1234;
    req_valid[D] = 1'b1;
    @(posedge clk);
    #1 req_valid[D] = 1'b0;
    @(negedge clk);              // in WAIT
    if (rsp_valid[D]) saw_rsp = 1;
    rst[D] = 1'b1;
    @(negedge clk);              // edge that would have entered RESP
    if (rsp_valid[D]) saw_rsp = 1;
    checks++; if (gpio[D] !== 8'h00) begin failures++; $display("FAIL midrst_gpio got=%h exp=00", gpio[D]); end
    rst[D] = 1'b0;
    #1;
    checks++; if (req_ready[D] !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", req_ready[D]); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid[D]) saw_rsp = 1;
    end
    checks++; if (saw_rsp) begin failures++; $display("FAIL midrst_rsp got=rsp_valid exp=no_rsp_valid"); end
    do_access(D, 0, LW, 32'd8, 32'd0, rd, er, lat, rl, po);
    checks++; if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL midrst_mem got=%h exp=0badf00d", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_defaults();
    test_subword();
    test_big_endian();
    test_errors();
    test_gpio();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
